// File: rtl/ras_pkg.sv
// Shared definitions for the return address stack: operation codes and
// default geometry.
package ras_pkg;

   localparam logic [1:0] RAS_NOAC = 2'b00;
   localparam logic [1:0] RAS_PUSH = 2'b01;
   localparam logic [1:0] RAS_POP  = 2'b10;
   localparam logic [1:0] RAS_POPU = 2'b11;

   localparam int unsigned RAS_DATA_W = 64;
   localparam int unsigned RAS_DEPTH  = 16;

endpackage

// File: rtl/ras_mem.sv
// Return address storage: flop array with async clear, one synchronous write
// port and one asynchronous read port.
module ras_mem #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_en_i,
   input  logic [PTR_W-1:0]  wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [PTR_W-1:0]  rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ras_ckpt.sv
// Checkpointable return address stack: speculative push/pop from fetch,
// pointer/count restore with optional top-entry repair on retire flush.
module ras_ckpt
   import ras_pkg::*;
#(
   parameter int unsigned DATA_W = RAS_DATA_W,
   parameter int unsigned DEPTH  = RAS_DEPTH,
   parameter int unsigned PTR_W  = $clog2(DEPTH),
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ctl_vld_i,
   input  logic [1:0]        ctl_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              flush_i,
   input  logic [PTR_W-1:0]  flush_ptr_i,
   input  logic [CNT_W-1:0]  flush_cnt_i,
   input  logic              flush_wr_i,
   input  logic [DATA_W-1:0] flush_data_i,
   output logic [DATA_W-1:0] top_data_o,
   output logic              top_vld_o,
   output logic [PTR_W-1:0]  ckpt_ptr_o,
   output logic [CNT_W-1:0]  ckpt_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;

   // Next state and the single write port; flush wins over any speculative op.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = ptr_q;
      wr_data = push_data_i;
      if (flush_i) begin
         ptr_d   = flush_ptr_i;
         cnt_d   = flush_cnt_i;
         wr_en   = flush_wr_i;
         wr_addr = flush_ptr_i;
         wr_data = flush_data_i;
      end else if (ctl_vld_i) begin
         case (ctl_i)
            RAS_NOAC: ;
            RAS_PUSH: begin
               ptr_d   = ptr_q + PTR_W'(1);
               wr_en   = 1'b1;
               wr_addr = ptr_q + PTR_W'(1);
               if (cnt_q != CNT_FULL) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RAS_POP: begin
               if (cnt_q != '0) begin
                  ptr_d = ptr_q - PTR_W'(1);
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            RAS_POPU: begin
               wr_en = 1'b1;
               if (cnt_q == '0) begin
                  cnt_d = CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   ras_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (ptr_q),
      .rd_data_o (rd_data)
   );

   assign top_data_o = rd_data;
   assign top_vld_o  = (cnt_q != '0);
   assign ckpt_ptr_o = ptr_d;
   assign ckpt_cnt_o = cnt_d;

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt (DEPTH=4): a stack model predicts checkpoint
// outputs for the current cycle and the top entry for the following cycle.
module tb_ras_ckpt;

   localparam int unsigned DW = 64;
   localparam int unsigned DP = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          ctl_vld_i;
   logic [1:0]    ctl_i;
   logic [DW-1:0] push_data_i;
   logic          flush_i;
   logic [1:0]    flush_ptr_i;
   logic [2:0]    flush_cnt_i;
   logic          flush_wr_i;
   logic [DW-1:0] flush_data_i;
   logic [DW-1:0] top_data_o;
   logic          top_vld_o;
   logic [1:0]    ckpt_ptr_o;
   logic [2:0]    ckpt_cnt_o;

   ras_ckpt #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .ctl_vld_i    (ctl_vld_i),
      .ctl_i        (ctl_i),
      .push_data_i  (push_data_i),
      .flush_i      (flush_i),
      .flush_ptr_i  (flush_ptr_i),
      .flush_cnt_i  (flush_cnt_i),
      .flush_wr_i   (flush_wr_i),
      .flush_data_i (flush_data_i),
      .top_data_o   (top_data_o),
      .top_vld_o    (top_vld_o),
      .ckpt_ptr_o   (ckpt_ptr_o),
      .ckpt_cnt_o   (ckpt_cnt_o)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct { int ptr; int cnt; } ck_t;
   typedef struct { logic [DW-1:0] data; logic vld; } tp_t;
   ck_t ck_q[$];
   tp_t tp_q[$];

   // Reference stack: plain array plus integer top index and occupancy.
   logic [DW-1:0] m_mem [DP];
   int m_ptr, m_cnt;
   logic [1:0] seen_ptr;
   logic [2:0] seen_cnt;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < int'(DP); i++) m_mem[i] = '0;
      m_ptr = 0;
      m_cnt = 0;
   endfunction

   function automatic void model_apply(input logic vld, input logic [1:0] op, input logic [DW-1:0] d,
                                       input logic fl, input int fp, input int fc,
                                       input logic fw, input logic [DW-1:0] fd);
      if (fl) begin
         m_ptr = fp;
         m_cnt = fc;
         if (fw) m_mem[fp] = fd;
      end else if (vld) begin
         if (op == 2'd1) begin
            m_ptr = (m_ptr + 1) % DP;
            m_mem[m_ptr] = d;
            m_cnt = (m_cnt < int'(DP)) ? m_cnt + 1 : int'(DP);
         end else if (op == 2'd2) begin
            if (m_cnt > 0) begin
               m_ptr = (m_ptr + DP - 1) % DP;
               m_cnt = m_cnt - 1;
            end
         end else if (op == 2'd3) begin
            m_mem[m_ptr] = d;
            if (m_cnt == 0) m_cnt = 1;
         end
      end
   endfunction

   // Called at posedge+2; drives one cycle of stimulus, returns at next posedge+2.
   task automatic step(input logic vld, input logic [1:0] op, input logic [DW-1:0] d,
                       input logic fl, input logic [1:0] fp, input logic [2:0] fc,
                       input logic fw, input logic [DW-1:0] fd);
      ck_t c;
      tp_t t;
      ctl_vld_i = vld; ctl_i = op; push_data_i = d;
      flush_i = fl; flush_ptr_i = fp; flush_cnt_i = fc; flush_wr_i = fw; flush_data_i = fd;
      model_apply(vld, op, d, fl, int'(fp), int'(fc), fw, fd);
      c.ptr = m_ptr; c.cnt = m_cnt;
      t.data = m_mem[m_ptr]; t.vld = (m_cnt != 0);
      ck_q.push_back(c);
      tp_q.push_back(t);
      #1;
      seen_ptr = ckpt_ptr_o;
      seen_cnt = ckpt_cnt_o;
      @(posedge clock);
      #2;
   endtask

   task automatic op(input logic [1:0] o, input logic [DW-1:0] d);
      step(1'b1, o, d, 1'b0, 2'd0, 3'd0, 1'b0, '0);
   endtask

   task automatic idle();
      step(1'b0, 2'd0, '0, 1'b0, 2'd0, 3'd0, 1'b0, '0);
   endtask

   task automatic flush(input logic [1:0] fp, input logic [2:0] fc, input logic fw, input logic [DW-1:0] fd);
      step(1'b0, 2'd0, '0, 1'b1, fp, fc, fw, fd);
   endtask

   // Checkpoint outputs are checked mid-cycle against the op currently driven.
   always @(negedge clock) begin
      if (ck_q.size() > 0) begin
         ck_t c;
         c = ck_q.pop_front();
         chk("ckpt_ptr", DW'(ckpt_ptr_o), DW'(c.ptr));
         chk("ckpt_cnt", DW'(ckpt_cnt_o), DW'(c.cnt));
      end
   end

   // Top entry is checked just after the edge that consumed the op.
   always @(posedge clock) begin
      #1;
      if (tp_q.size() > 0) begin
         tp_t t;
         t = tp_q.pop_front();
         chk("top_data", top_data_o, t.data);
         chk("top_vld", DW'(top_vld_o), DW'(t.vld));
      end
   end

   initial begin
      logic [1:0] rec_ptr;
      logic [2:0] rec_cnt;
      int exp_cnt;
      logic [DW-1:0] exp_tops [5];

      reset_n = 1'b0;
      ctl_vld_i = 1'b0; ctl_i = 2'd0; push_data_i = '0;
      flush_i = 1'b0; flush_ptr_i = '0; flush_cnt_i = '0; flush_wr_i = 1'b0; flush_data_i = '0;
      model_reset();
      #12;
      chk("rst_top_vld", DW'(top_vld_o), '0);
      chk("rst_ckpt_ptr", DW'(ckpt_ptr_o), '0);
      chk("rst_ckpt_cnt", DW'(ckpt_cnt_o), '0);
      chk("rst_top_data", top_data_o, '0);
      reset_n = 1'b1;
      @(posedge clock);
      #2;

      // Push three, pop two.
      exp_tops[0] = 64'hA0; exp_tops[1] = 64'hB0; exp_tops[2] = 64'hC0;
      exp_tops[3] = 64'hB0; exp_tops[4] = 64'hA0;
      op(2'd1, 64'hA0); chk("seq_top0", top_data_o, exp_tops[0]);
      op(2'd1, 64'hB0); chk("seq_top1", top_data_o, exp_tops[1]);
      op(2'd1, 64'hC0); chk("seq_top2", top_data_o, exp_tops[2]);
      op(2'd2, '0);     chk("seq_top3", top_data_o, exp_tops[3]);
      op(2'd2, '0);     chk("seq_top4", top_data_o, exp_tops[4]);
      idle();
      chk("seq_cnt", DW'(ckpt_cnt_o), 64'd1);
      chk("seq_vld", DW'(top_vld_o), 64'd1);

      // Overflow overwrites the oldest entry.
      flush(2'd0, 3'd0, 1'b0, '0);
      for (int i = 1; i <= 5; i++) op(2'd1, DW'(i));
      idle();
      chk("ovf_top", top_data_o, 64'h5);
      chk("ovf_ptr", DW'(ckpt_ptr_o), 64'd1);
      chk("ovf_cnt", DW'(ckpt_cnt_o), 64'd4);
      op(2'd2, '0); chk("ovf_pop1", top_data_o, 64'h4);
      op(2'd2, '0); chk("ovf_pop2", top_data_o, 64'h3);
      op(2'd2, '0); chk("ovf_pop3", top_data_o, 64'h2);
      op(2'd2, '0); chk("ovf_pop4_vld", DW'(top_vld_o), 64'd0);
      op(2'd2, '0);
      idle();
      chk("udf_ptr", DW'(ckpt_ptr_o), 64'd1);
      chk("udf_cnt", DW'(ckpt_cnt_o), 64'd0);

      // POPU replaces the top in place.
      flush(2'd2, 3'd2, 1'b1, 64'hB0);
      chk("popu_pre", top_data_o, 64'hB0);
      op(2'd3, 64'hEE);
      chk("popu_top", top_data_o, 64'hEE);
      idle();
      chk("popu_ptr", DW'(ckpt_ptr_o), 64'd2);
      chk("popu_cnt", DW'(ckpt_cnt_o), 64'd2);

      // Flush beats a same-cycle push; 0x99 must not land anywhere.
      step(1'b1, 2'd1, 64'h99, 1'b1, 2'd2, 3'd3, 1'b1, 64'h77);
      chk("fl_top", top_data_o, 64'h77);
      idle();
      chk("fl_ptr", DW'(ckpt_ptr_o), 64'd2);
      chk("fl_cnt", DW'(ckpt_cnt_o), 64'd3);
      for (int i = 0; i < int'(DP); i++) begin
         flush(2'(i), 3'd1, 1'b0, '0);
         checks++;
         if (top_data_o === 64'h99) begin
            errors++;
            $display("FAIL fl_no99: entry %0d holds 0x%0h, must not be 0x99", i, top_data_o);
         end
      end

      // Checkpoint round trip across wrong-path operations.
      flush(2'd1, 3'd2, 1'b0, '0);
      op(2'd1, 64'h42);
      rec_ptr = seen_ptr;
      rec_cnt = seen_cnt;
      exp_cnt = m_cnt;
      op(2'd2, '0); op(2'd2, '0); op(2'd2, '0);
      op(2'd1, 64'hDEAD);
      flush(rec_ptr, rec_cnt, 1'b1, 64'h42);
      chk("rt_top", top_data_o, 64'h42);
      idle();
      chk("rt_cnt", DW'(ckpt_cnt_o), DW'(exp_cnt));

      // Randomized mix of ops and flushes.
      for (int n = 0; n < 400; n++) begin
         logic [DW-1:0] d;
         d = {$urandom, $urandom};
         if ($urandom_range(0, 15) == 0)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d, 1'b1,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom});
         else
            step(1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), d,
                 1'b0, '0, '0, 1'b0, '0);
      end

      // Asynchronous reset mid-operation clears state with no pending write.
      ctl_vld_i = 1'b1; ctl_i = 2'd1; push_data_i = 64'h5A;
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_top_data", top_data_o, '0);
      chk("arst_top_vld", DW'(top_vld_o), '0);
      ctl_vld_i = 1'b0;
      #1;
      chk("arst_ckpt_ptr", DW'(ckpt_ptr_o), '0);
      chk("arst_ckpt_cnt", DW'(ckpt_cnt_o), '0);
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      model_reset();
      @(posedge clock);
      #2;
      chk("arst_after_data", top_data_o, '0);
      chk("arst_after_vld", DW'(top_vld_o), '0);
      op(2'd3, 64'h1234);
      op(2'd1, 64'h5678);
      op(2'd2, '0);
      idle();

      checks++;
      if (ck_q.size() != 0 || tp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d entries left, expected 0/0", ck_q.size(), tp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Parametrised, checkpointable return address stack for the fetch stage. It replaces the fixed 64x16 RAS. It adds configurable width and depth, an occupancy count with a valid output, and overwrite-oldest on overflow. On a retire flush it restores the pointer and count and optionally repairs the top entry. Fetch drives predicted push/pop operations. The retire stage restores the state checkpointed with each branch.

## Interface
Parameters:
- DATA_W, 64, return address width
- DEPTH, 16, number of entries; power of two, at least 2
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override)
- CNT_W, $clog2(DEPTH)+1, occupancy count width (derived)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ctl_vld_i  in  1  speculative operation valid; fetch has already gated it with stall, hit and override
- ctl_i  in  2  operation code: 00 NOAC, 01 PUSH, 10 POP, 11 POPU (pop then push)
- push_data_i  in  DATA_W  return address to push
- flush_i  in  1  retire flush; restore state from checkpoint
- flush_ptr_i  in  PTR_W  checkpointed pointer
- flush_cnt_i  in  CNT_W  checkpointed count
- flush_wr_i  in  1  on flush, rewrite entry[flush_ptr_i]
- flush_data_i  in  DATA_W  repair data for the top entry
- top_data_o  out  DATA_W  entry[ptr] (current top)
- top_vld_o  out  1  cnt != 0
- ckpt_ptr_o  out  PTR_W  next-state pointer, stored with the branch
- ckpt_cnt_o  out  CNT_W  next-state count, stored with the branch

## Operation
- State:
  - ptr (PTR_W) points to the most recent push.
  - cnt (0..DEPTH) is the occupancy.
  - mem holds DEPTH x DATA_W entries.
- All pointer arithmetic is modulo DEPTH and wraps naturally in PTR_W bits.
- Operations, applied when ctl_vld_i=1 and flush_i=0:
  - NOAC: no change.
  - PUSH: ptr<=ptr+1; mem[ptr+1]<=push_data_i; cnt<=min(cnt+1, DEPTH).
  - POP: if cnt!=0, ptr<=ptr-1 and cnt<=cnt-1. If cnt=0 (underflow), no change.
  - POPU: mem[ptr]<=push_data_i; ptr and cnt unchanged. This also applies when cnt=0, in which case cnt becomes 1.
- Overflow: PUSH at cnt=DEPTH overwrites the oldest entry, and cnt stays DEPTH.
- Flush:
  - ptr<=flush_ptr_i and cnt<=flush_cnt_i.
  - If flush_wr_i=1, mem[flush_ptr_i]<=flush_data_i.
- Flush has priority. Any ctl_vld_i operation in the same cycle is discarded and causes no memory write.
- ckpt_ptr_o and ckpt_cnt_o are combinational and equal the values ptr and cnt take at the next edge.
- top_data_o is combinational from registered ptr and mem. There is no write bypass.
- Reset state:
  - ptr=0, cnt=0, all mem entries=0.
  - Outputs: top_data_o=0, top_vld_o=0, ckpt_ptr_o=0, ckpt_cnt_o=0 while no operation is presented.
- Reset asserted mid-operation returns all state to the reset state immediately, with no pending write.

## Timing
- Single-cycle update.
- An operation or flush presented in cycle N is visible on top_data_o and top_vld_o in cycle N+1.
- ckpt_* outputs are valid in cycle N, combinationally from the inputs.
- Exactly one memory write occurs per cycle at most.
- No handshake: the block always accepts. Fetch holds ctl_vld_i low when stalled.
- Back-to-back operations are allowed every cycle, with no bubbles.

## Structure
- Shared package ras_pkg:
  - localparams RAS_NOAC=2'b00, RAS_PUSH=2'b01, RAS_POP=2'b10, RAS_POPU=2'b11.
  - Parameter defaults DATA_W=64, DEPTH=16.
- Sub-module ras_mem:
  - DATA_W x DEPTH flop array with async reset to 0, one synchronous write port and one asynchronous read port.
- Top level holds the ptr/cnt registers, next-state logic, write-port mux (flush repair vs. speculative write) and output assigns.

## Test plan
All scenarios use DEPTH=4 and DATA_W=64.
- Reset, then idle: top_vld_o=0, ckpt_ptr_o=0, ckpt_cnt_o=0, top_data_o=0.
- PUSH 0xA0, 0xB0, 0xC0 on consecutive cycles, then POP twice:
  - top_data_o reads 0xA0, 0xB0, 0xC0, then 0xB0, 0xA0.
  - cnt ends at 1 and top_vld_o=1.
- Overflow: PUSH 0x1, 0x2, 0x3, 0x4, 0x5:
  - cnt saturates at 4, ptr=1 and top_data_o=0x5.
  - Four POPs then return 0x4, 0x3, 0x2, then cnt=0 and top_vld_o=0.
  - A fifth POP leaves ptr and cnt unchanged.
- POPU on top=0xB0 with push_data_i=0xEE: top_data_o=0xEE next cycle; ptr and cnt unchanged.
- Flush with flush_ptr_i=2, flush_cnt_i=3, flush_wr_i=1, flush_data_i=0x77, and a PUSH 0x99 presented in the same cycle:
  - ptr=2, cnt=3, top_data_o=0x77.
  - 0x99 is written nowhere.
- Checkpoint round trip:
  - Record ckpt_ptr_o and ckpt_cnt_o at a PUSH of 0x42.
  - Run 3 wrong-path POPs and 1 wrong-path PUSH.
  - Flush with the recorded values and flush_wr_i=1, flush_data_i=0x42.
  - top_data_o returns to 0x42 with the recorded cnt.
